brent_kung_arbiter: RTL and testbench
=====================================

// Module: brent_kung_arbiter
// PURPOSE
//  Shares one combinational 12-bit BrentKung adder between NREQ requesters.
//  Round-robin arbitration, valid/ready handshakes on each request port and on one response port.
//  Operands and result are registered, so the adder sees stable inputs for a full cycle.
//  Sits between the requesting datapath units and the single adder instance.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  IDW    2   width of rsp_id; must satisfy 2**IDW >= NREQ
//  Adder width is fixed at 12 by the adder netlist; sum is 13 bits (carry-out in bit 12).
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   NREQ     request i has operands pending
//  req_ready  out  NREQ     one-hot; operands of requester i accepted this cycle
//  req_a      in   NREQ*12  operand A, requester i in bits [12*i+11:12*i]
//  req_b      in   NREQ*12  operand B, same packing
//  rsp_valid  out  1        result available
//  rsp_ready  in   1        consumer takes result
//  rsp_sum    out  13       A+B; bit 12 = carry-out
//  rsp_id     out  IDW      index of the requester that owns rsp_sum
// BEHAVIOUR
//  Adder hookup: INPUTS[2k]=op_a[k], INPUTS[2k+1]=op_b[k] (k=0..11); OUTS[12:0] -> sum.
//  Reset (async, any time): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0,
//   op_a=op_b=0. An in-flight operation is discarded.
//  FSM states:
//   IDLE  No operation held.
//         If any req_valid: grant winner g, assert req_ready[g] combinationally,
//         latch op_a/op_b/id on the edge, then go to CALC.
//   CALC  Adder evaluates op regs. On the edge, rsp_sum<=adder out, rsp_id<=id, then go to DONE.
//         req_ready=0 in this state.
//   DONE  rsp_valid=1. rsp_sum and rsp_id stay stable until the handshake.
//         rsp_ready=0: stay in DONE; no grant.
//         rsp_ready=1, no req_valid: go to IDLE.
//         rsp_ready=1 and req_valid: grant in the same cycle (req_ready[g]=1) and go to CALC.
//  Latency: accept at cycle T -> rsp_valid high from cycle T+2.
//  Best throughput: one result per 2 cycles.
//  Arbitration:
//   - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NREQ.
//   - On grant, rr_ptr <= (g+1) mod NREQ. rr_ptr does not change without a grant.
//  Handshake rules:
//   - req_ready is at most one-hot and only asserted when the matching req_valid=1.
//   - A requester holds its valid and operands stable until req_ready.
//   - The arbiter does not require this; it samples operands only in the grant cycle.
//   - rsp_valid never drops without rsp_ready=1.
//  Arithmetic: unsigned 12+12 -> 13 bits. No carry-in and no saturation.
//   0xFFF+0xFFF = 0x1FFE.
//  Boundaries:
//   - All requesters valid continuously: strict rotation 0,1,2,3,0...
//   - No requester waits more than NREQ-1 grants.
//   - Requester drops valid before grant: it is not served, and the pointer does not move for it.
//   - rst during CALC or DONE: the result is lost, rsp_valid=0 right away (async), req_ready=0.
// TESTING
//  1. Reset: rst high mid-DONE -> rsp_valid=0 immediately; after release, IDLE, rr_ptr=0.
//  2. Single request: req 2 with A=0xFFF, B=0x001 at T -> req_ready=4'b0100 at T;
//     rsp_valid at T+2, sum=0x1000, id=2.
//  3. All four valid, rsp_ready=1: grant order 0,1,2,3,0; results every 2 cycles.
//     With A=i, B=0x10*i, sums = 0x000, 0x011, 0x022, 0x033.
//  4. Back-pressure: rsp_ready=0 for 5 cycles in DONE -> sum and id stable, no req_ready.
//     Release -> next grant in the handshake cycle.
//  5. Max operands: A=B=0xFFF -> 0x1FFE. A=0xAAA, B=0x555 -> 0x0FFF. A=B=0 -> 0x000.
//  6. Fairness: req 0 held valid continuously, req 3 pulsed valid -> req 3 served within 2 grants.
//     Check req_ready is always one-hot and a subset of req_valid.

Source files
------------

// File: rtl/brent_kung_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : brent_kung_arbiter (with brent_kung_add12)
// Brief    : Round-robin sharing of one registered 12-bit Brent-Kung adder.
// Revision : 1.0
// ============================================================================

module brent_kung_add12 (
    input  logic [23:0] inputs_i,
    output logic [12:0] outs_o
);

    logic [11:0] w_a;
    logic [11:0] w_b;
    logic [11:0] w_h;
    logic [11:0] w_g;
    logic [11:0] w_p;

    // Group generate/propagate are refined in place: up-sweep then down-sweep.
    always_comb begin
        for (int k = 0; k < 12; k++) begin
            w_a[k] = inputs_i[2*k];
            w_b[k] = inputs_i[2*k+1];
        end
        w_h = w_a ^ w_b;
        w_g = w_a & w_b;
        w_p = w_h;
        for (int d = 1; d < 12; d = d * 2) begin
            for (int i = 2*d - 1; i < 12; i = i + 2*d) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                w_p[i] = w_p[i] & w_p[i-d];
            end
        end
        for (int d = 8; d >= 1; d = d / 2) begin
            for (int i = 3*d - 1; i < 12; i = i + 2*d) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                w_p[i] = w_p[i] & w_p[i-d];
            end
        end
        outs_o[0] = w_h[0];
        for (int i = 1; i < 12; i++) begin
            outs_o[i] = w_h[i] ^ w_g[i-1];
        end
        outs_o[12] = w_g[11];
    end

endmodule

module brent_kung_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*12-1:0]   req_a,
    input  logic [NREQ*12-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [12:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id
);

    localparam int c_ADD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDW-1:0]       rr_ptr_q;
    logic [c_ADD_W-1:0]   op_a_q;
    logic [c_ADD_W-1:0]   op_b_q;
    logic [IDW-1:0]       op_id_q;
    logic [12:0]          sum_q;
    logic [IDW-1:0]       rsp_id_q;

    logic                 w_found;
    logic [IDW-1:0]       w_gnt;
    logic [c_ADD_W-1:0]   w_a;
    logic [c_ADD_W-1:0]   w_b;
    logic                 w_grant;
    logic [2*c_ADD_W-1:0] w_adder_in;
    logic [12:0]          w_sum;

    // Search order starts at the pointer; the outer loop sets priority.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_a     = '0;
        w_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && req_valid[j] && (j == ((int'(rr_ptr_q) + k) % NREQ))) begin
                    w_found = 1'b1;
                    w_gnt   = IDW'(j);
                    w_a     = req_a[c_ADD_W*j +: c_ADD_W];
                    w_b     = req_b[c_ADD_W*j +: c_ADD_W];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        w_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    if (w_found) begin
                        w_grant = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = w_grant && (w_gnt == IDW'(j));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_id_q  <= '0;
            sum_q    <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_grant) begin
                op_a_q   <= w_a;
                op_b_q   <= w_b;
                op_id_q  <= w_gnt;
                rr_ptr_q <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);
            end
            if (state_q == ST_CALC) begin
                sum_q    <= w_sum;
                rsp_id_q <= op_id_q;
            end
        end
    end

    for (genvar k = 0; k < c_ADD_W; k++) begin : g_pack
        assign w_adder_in[2*k]   = op_a_q[k];
        assign w_adder_in[2*k+1] = op_b_q[k];
    end

    brent_kung_add12 u_adder (
        .inputs_i (w_adder_in),
        .outs_o   (w_sum)
    );

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_sum   = sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_brent_kung_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_brent_kung_arbiter
// Brief    : Vector table, multi-cycle sequences and a response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_brent_kung_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_a;
    logic [47:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [12:0] rsp_sum;
    logic [1:0]  rsp_id;

    logic [11:0] ta [4];
    logic [11:0] tb [4];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [12:0] sum;
    } exp_t;

    typedef struct {
        int          id;
        logic [11:0] a;
        logic [11:0] b;
        logic [12:0] sum;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t vecs [6];

    assign req_a = {ta[3], ta[2], ta[1], ta[0]};
    assign req_b = {tb[3], tb[2], tb[1], tb[0]};

    always #5 clk = ~clk;

    brent_kung_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Protocol checks plus scoreboard: push at grant, pop at response handshake.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (((req_ready & (req_ready - 4'd1)) != 4'd0) || ((req_ready & ~req_valid) != 4'd0)) begin
                errors++;
                $display("FAIL ready_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got sum 0x%0h id %0d, expected none", rsp_sum, rsp_id);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_sum", 32'(rsp_sum), 32'(sb_e.sum));
                    check("sb_id", 32'(rsp_id), 32'(sb_e.id));
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (req_ready[j]) begin
                    sb_q.push_back('{id: 2'(j), sum: {1'b0, ta[j]} + {1'b0, tb[j]}});
                end
            end
        end
    end

    task automatic single(input int id, input logic [11:0] a, input logic [11:0] b,
                          input logic [12:0] exp_sum);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        @(posedge clk); #1;
        ta[id] = a;
        tb[id] = b;
        req_valid = oh;
        @(negedge clk);
        check("vec_grant", 32'(req_ready), 32'(oh));
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("vec_calc_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("vec_lat_valid", 32'(rsp_valid), 32'd1);
        check("vec_sum", 32'(rsp_sum), 32'(exp_sum));
        check("vec_id", 32'(rsp_id), 32'(id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gseq [5];
        int gcyc [5];
        int n;
        int grants;
        int served;

        vecs[0] = '{2, 12'hFFF, 12'h001, 13'h1000};
        vecs[1] = '{1, 12'hFFF, 12'hFFF, 13'h1FFE};
        vecs[2] = '{0, 12'hAAA, 12'h555, 13'h0FFF};
        vecs[3] = '{3, 12'h000, 12'h000, 13'h0000};
        vecs[4] = '{0, 12'h123, 12'h456, 13'h0579};
        vecs[5] = '{3, 12'h800, 12'h800, 13'h1000};

        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ta[i] = '0;
            tb[i] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Single requests, including operand extremes.
        rsp_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            single(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sum);
        end

        // Reset in DONE must drop rsp_valid without waiting for a clock.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        ta[2] = 12'h0F0;
        tb[2] = 12'h00F;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #3;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_sum", 32'(rsp_sum), 32'd0);
        check("async_rst_id", 32'(rsp_id), 32'd0);
        sb_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;

        // Rotation from a freshly reset pointer.
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            ta[i] = 12'(i);
            tb[i] = 12'(16 * i);
            gseq[i] = -1;
            gcyc[i] = -1;
        end
        gseq[4] = -1;
        gcyc[4] = -1;
        req_valid = 4'b1111;
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                for (int j = 0; j < 4; j++) begin
                    if (req_ready[j]) gseq[n] = j;
                end
                gcyc[n] = c;
                n++;
            end
        end
        check("rot_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("rot_order", 32'(gseq[i]), 32'(i % 4));
        end
        for (int i = 1; i < 5; i++) begin
            check("rot_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (4) @(posedge clk);

        // Back-pressure in DONE, then grant in the handshake cycle.
        #1;
        rsp_ready = 1'b0;
        ta[1] = 12'h321;
        tb[1] = 12'h0CF;
        req_valid = 4'b0010;
        @(negedge clk);
        check("bp_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        ta[3] = 12'h100;
        tb[3] = 12'h200;
        req_valid = 4'b1000;
        @(negedge clk);
        check("bp_calc_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_sum", 32'(rsp_sum), 32'h3F0);
            check("bp_id", 32'(rsp_id), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_valid", 32'(rsp_valid), 32'd1);
        check("bp_next_sum", 32'(rsp_sum), 32'h300);
        check("bp_next_id", 32'(rsp_id), 32'd3);

        // Fairness: requester 3 must not starve behind a constant requester 0.
        @(posedge clk); #1;
        ta[0] = 12'h00A;
        tb[0] = 12'h00B;
        req_valid = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        ta[3] = 12'h7FF;
        tb[3] = 12'h001;
        req_valid = 4'b1001;
        grants = 0;
        served = 0;
        for (int c = 0; c < 20 && served == 0; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) grants++;
            if (req_ready[3]) served = 1;
        end
        check("fair_served", 32'(served), 32'd1);
        check("fair_grants_le2", 32'(grants <= 2), 32'd1);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        repeat (6) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
